frame_sync_descrambler: RTL and testbench
=========================================

// Module: frame_sync_descrambler
// PURPOSE
//  Serial receive front end: hunts for a parametrised sync word, then descrambles a
//  fixed-length payload with an additive Fibonacci LFSR keystream. After lock it re-checks
//  the sync header of every frame (flywheel) and drops back to hunt after MISS_LIMIT misses.
//  Sits between the serial line sampler and the payload deframer.
// PARAMETERS
//  SYNC_LEN    4        sync header length in bits (>=2)
//  SYNC_WORD   4'b1111  header pattern, MSB received first
//  LFSR_W      3        keystream LFSR width (>=2)
//  LFSR_TAPS   3'b101   feedback mask: fb = ^(state & LFSR_TAPS)
//  LFSR_SEED   3'b111   state loaded at each payload start; nonzero
//  PAYLOAD_LEN 10       payload bits per frame (>=1)
//  MISS_LIMIT  2        consecutive header misses before loss of lock (>=1)
// PORTS
//  CLK          in   1  system clock, all logic on rising edge
//  RSTn         in   1  synchronous active-low reset
//  in_bit       in   1  serial data bit
//  in_en        in   1  bit strobe; in_bit sampled only when in_en=1
//  out_bit      out  1  descrambled payload bit
//  out_valid    out  1  1-cycle strobe qualifying out_bit
//  frame_start  out  1  1-cycle strobe, coincident with out_valid of payload bit 0
//  locked       out  1  1 while in PAYLOAD/CHECK states
//  sync_err     out  1  1-cycle strobe on header mismatch while locked
// BEHAVIOUR
//  - Reset (RSTn=0 at posedge): state=HUNT, shift reg=0, counters=0, LFSR=LFSR_SEED,
//    miss count=0; out_bit, out_valid, frame_start, locked, sync_err all 0.
//  - Nothing advances on cycles with in_en=0; strobe outputs are 0 on those cycles.
//  - Shift reg: SYNC_LEN bits, sh <= {sh[SYNC_LEN-2:0], in_bit} on every in_en.
//  - HUNT: when updated sh == SYNC_WORD -> PAYLOAD, bit count=0, LFSR=SEED, locked<=1.
//    Overlapping matches allowed (bit-by-bit sliding compare, no minimum fill).
//  - PAYLOAD: per in_en, out_bit <= in_bit ^ S[LFSR_W-1], out_valid<=1, then
//    S <= {S[LFSR_W-2:0], ^(S & LFSR_TAPS)}; frame_start<=1 on bit 0. After bit
//    PAYLOAD_LEN-1 -> CHECK, header count=0.
//  - Lock-up guard: if next S would be all-zero, load LFSR_SEED instead.
//  - CHECK: collect SYNC_LEN bits; on last bit compare updated sh with SYNC_WORD:
//    match -> miss=0, PAYLOAD (LFSR=SEED). Mismatch -> sync_err<=1, miss+1;
//    if miss+1 == MISS_LIMIT -> HUNT, locked<=0, miss=0; else -> PAYLOAD (flywheel).
//    No output strobes during CHECK except sync_err.
//  - Latency: outputs registered, 1 CLK after the in_en sample that produced them.
//  - Keystream (defaults): S0=111, bits k=0..9 = 1,1,1,0,1,0,0,1,1,1; period 7.
//  - Counters sized $clog2(max+1); wrap never occurs, counts reset at each state entry.
//  - Reset mid-frame: all state discarded, next cycle is HUNT with outputs 0.
//  - Simultaneous RSTn=0 and in_en=1: reset wins, input bit discarded.
// TESTING
//  1 Reset: RSTn=0 with in_en=1, random in_bit for 5 cycles -> all outputs 0, locked=0.
//  2 Lock+descramble: 1111 then ten 0s, in_en=1 every cycle -> locked 1 after 4th bit;
//    out_bit sequence 1110100111, frame_start on first out_valid only.
//  3 Gapped strobe: same frame, in_en=1 every 3rd cycle -> identical out_bit sequence,
//    out_valid exactly 1 cycle after each sampled bit, 0 elsewhere.
//  4 Flywheel: frame, header 1011, frame -> one sync_err pulse, locked stays 1,
//    second payload descrambled with fresh seed (all-0 in -> 1110100111).
//  5 Loss of lock: two consecutive bad headers (0000,0000) -> 2 sync_err pulses, locked=0
//    after second; following 1111 relocks.
//  6 Hunt overlap + mid-frame reset: 111111 -> lock on 4th 1; RSTn=0 at payload bit 5
//    -> next cycle HUNT, no further out_valid until new sync word.

Source files
------------

// File: rtl/frame_sync_descrambler.sv
// Serial receive front end: hunts for SYNC_WORD, then removes an additive LFSR keystream
// from each fixed-length payload while flywheel-checking the header of every frame.
module frame_sync_descrambler #(
  parameter int                  SYNC_LEN    = 4,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD   = 4'b1111,
  parameter int                  LFSR_W      = 3,
  parameter logic [LFSR_W-1:0]   LFSR_TAPS   = 3'b101,
  parameter logic [LFSR_W-1:0]   LFSR_SEED   = 3'b111,
  parameter int                  PAYLOAD_LEN = 10,
  parameter int                  MISS_LIMIT  = 2
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       in_bit,
  input  logic       in_en,
  output logic       out_bit,
  output logic       out_valid,
  output logic       frame_start,
  output logic       locked,
  output logic       sync_err,
  output logic [1:0] state_dbg
);

  // Handshake: in_bit is consumed only on cycles where in_en=1; every output strobe is
  // asserted for exactly one CLK, one cycle after the in_en sample that caused it.

  localparam int BCW = $clog2(PAYLOAD_LEN + 1);
  localparam int HCW = $clog2(SYNC_LEN + 1);
  localparam int MCW = $clog2(MISS_LIMIT + 1);

  localparam logic [BCW-1:0] BIT_LAST  = BCW'(PAYLOAD_LEN - 1);
  localparam logic [HCW-1:0] HDR_LAST  = HCW'(SYNC_LEN - 1);
  localparam logic [MCW-1:0] MISS_LAST = MCW'(MISS_LIMIT - 1);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_t;

  state_t              state;
  logic [SYNC_LEN-1:0] sh;
  logic [SYNC_LEN-1:0] sh_next;
  logic [LFSR_W-1:0]   lfsr;
  logic [LFSR_W-1:0]   lfsr_step;
  logic [LFSR_W-1:0]   lfsr_next;
  logic [BCW-1:0]      bit_cnt;
  logic [HCW-1:0]      hdr_cnt;
  logic [MCW-1:0]      miss_cnt;
  logic                sync_hit;

  assign sh_next   = {sh[SYNC_LEN-2:0], in_bit};
  assign sync_hit  = (sh_next == SYNC_WORD);
  assign lfsr_step = {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
  // An all-zero state would freeze the keystream, so reseed instead of entering it.
  assign lfsr_next = (lfsr_step == '0) ? LFSR_SEED : lfsr_step;
  assign state_dbg = state;

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state       <= HUNT;
      sh          <= '0;
      lfsr        <= LFSR_SEED;
      bit_cnt     <= '0;
      hdr_cnt     <= '0;
      miss_cnt    <= '0;
      out_bit     <= 1'b0;
      out_valid   <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      out_valid   <= 1'b0;
      frame_start <= 1'b0;
      sync_err    <= 1'b0;
      if (in_en) begin
        sh <= sh_next;
        case (state)
          HUNT: begin
            if (sync_hit) begin
              state   <= PAYLOAD;
              bit_cnt <= '0;
              lfsr    <= LFSR_SEED;
              locked  <= 1'b1;
            end
          end
          PAYLOAD: begin
            out_bit     <= in_bit ^ lfsr[LFSR_W-1];
            out_valid   <= 1'b1;
            frame_start <= (bit_cnt == '0);
            lfsr        <= lfsr_next;
            if (bit_cnt == BIT_LAST) begin
              state   <= CHECK;
              hdr_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          CHECK: begin
            if (hdr_cnt == HDR_LAST) begin
              bit_cnt <= '0;
              lfsr    <= LFSR_SEED;
              if (sync_hit) begin
                miss_cnt <= '0;
                state    <= PAYLOAD;
              end else begin
                sync_err <= 1'b1;
                if (miss_cnt == MISS_LAST) begin
                  state    <= HUNT;
                  locked   <= 1'b0;
                  miss_cnt <= '0;
                end else begin
                  // Flywheel: trust the frame timing and keep descrambling.
                  miss_cnt <= miss_cnt + 1'b1;
                  state    <= PAYLOAD;
                end
              end
            end else begin
              hdr_cnt <= hdr_cnt + 1'b1;
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_sync_descrambler.sv
// Bench for frame_sync_descrambler: directed frames plus random traffic, compared every
// cycle against a bit-level reference model of the framing rules.
module tb_frame_sync_descrambler;

  localparam int             SYNC_LEN    = 4;
  localparam logic [3:0]     SYNC_WORD   = 4'b1111;
  localparam int             LFSR_W      = 3;
  localparam int             LFSR_TAPS   = 5;
  localparam int             LFSR_SEED   = 7;
  localparam int             PAYLOAD_LEN = 10;
  localparam int             MISS_LIMIT  = 2;
  localparam logic [9:0]     KS_REF      = 10'b1110100111;

  // ---------------- clock / reset ----------------
  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic       in_bit = 1'b0;
  logic       in_en = 1'b0;
  logic       out_bit, out_valid, frame_start, locked, sync_err;
  logic [1:0] state_dbg;

  always #5 CLK = ~CLK;

  frame_sync_descrambler dut (
    .CLK(CLK), .RSTn(RSTn), .in_bit(in_bit), .in_en(in_en),
    .out_bit(out_bit), .out_valid(out_valid), .frame_start(frame_start),
    .locked(locked), .sync_err(sync_err), .state_dbg(state_dbg)
  );

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Modes: 0 searching, 1 inside payload, 2 collecting a header.
  logic     ks[PAYLOAD_LEN];
  logic     m_win[$];
  int       m_mode, m_k, m_hdr, m_miss;
  logic     m_locked;
  logic     e_valid, e_bit, e_fs, e_err;
  logic [0:0] exp_q[$];

  function automatic void build_ks();
    int s;
    int nxt;
    s = LFSR_SEED;
    for (int k = 0; k < PAYLOAD_LEN; k++) begin
      ks[k] = logic'((s >> (LFSR_W - 1)) & 1);
      nxt = ((s * 2) + ($countones(s & LFSR_TAPS) % 2)) % (1 << LFSR_W);
      s = (nxt == 0) ? LFSR_SEED : nxt;
    end
  endfunction

  function automatic void model_reset();
    m_win.delete();
    for (int i = 0; i < SYNC_LEN; i++) m_win.push_back(1'b0);
    m_mode = 0; m_k = 0; m_hdr = 0; m_miss = 0;
    m_locked = 1'b0;
    e_bit = 1'b0;
    exp_q.delete();
  endfunction

  function automatic logic window_is_sync();
    for (int i = 0; i < SYNC_LEN; i++)
      if (m_win[i] !== SYNC_WORD[SYNC_LEN-1-i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_step(input logic rstn, input logic en, input logic b);
    logic hit;
    e_valid = 1'b0; e_fs = 1'b0; e_err = 1'b0;
    if (!rstn) begin
      model_reset();
      return;
    end
    if (!en) return;
    m_win.push_back(b);
    void'(m_win.pop_front());
    hit = window_is_sync();
    case (m_mode)
      0: if (hit) begin m_mode = 1; m_k = 0; m_locked = 1'b1; end
      1: begin
        e_bit = b ^ ks[m_k];
        e_valid = 1'b1;
        e_fs = (m_k == 0);
        exp_q.push_back(e_bit);
        m_k++;
        if (m_k == PAYLOAD_LEN) begin m_mode = 2; m_hdr = 0; end
      end
      default: begin
        m_hdr++;
        if (m_hdr == SYNC_LEN) begin
          m_k = 0;
          if (hit) begin
            m_miss = 0; m_mode = 1;
          end else begin
            e_err = 1'b1;
            m_miss++;
            if (m_miss == MISS_LIMIT) begin
              m_mode = 0; m_locked = 1'b0; m_miss = 0;
            end else begin
              m_mode = 1;
            end
          end
        end
      end
    endcase
  endfunction

  // ---------------- driver ----------------
  logic [15:0] got_bits;
  int          got_n;
  int          err_cnt;

  task automatic cycle(input logic rstn, input logic en, input logic b);
    logic [0:0] exp_b;
    @(negedge CLK);
    RSTn = rstn; in_en = en; in_bit = b;
    model_step(rstn, en, b);
    @(posedge CLK);
    #1;
    check_eq("out_valid", out_valid, e_valid);
    check_eq("frame_start", frame_start, e_fs);
    check_eq("locked", locked, m_locked);
    check_eq("sync_err", sync_err, e_err);
    if (e_valid) check_eq("out_bit", out_bit, e_bit);
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) check_eq("sb_underflow", exp_q.size(), 1);
      else begin
        exp_b = exp_q.pop_front();
        check_eq("sb_bit", out_bit, exp_b);
      end
      got_bits = {got_bits[14:0], out_bit};
      got_n++;
    end
    if (sync_err === 1'b1) err_cnt++;
  endtask

  task automatic send_word(input logic [31:0] value, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      cycle(1'b1, 1'b1, value[i]);
      for (int g = 1; g < gap; g++) cycle(1'b1, 1'b0, 1'($urandom_range(1, 0)));
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 1'($urandom_range(1, 0)));
    got_bits = '0; got_n = 0; err_cnt = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    build_ks();
    model_reset();
    got_bits = '0; got_n = 0; err_cnt = 0;

    // 1: reset with in_en high and random data
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'($urandom_range(1, 0)));
    check_eq("t1_locked", locked, 0);

    // 2: lock and descramble, back-to-back bits
    do_reset();
    send_word(32'hF, 4, 1);
    check_eq("t2_locked", locked, 1);
    send_word(32'h0, PAYLOAD_LEN, 1);
    check_eq("t2_count", got_n, PAYLOAD_LEN);
    check_eq("t2_seq", got_bits[9:0], KS_REF);

    // 3: same frame with a strobe every 3rd cycle
    do_reset();
    send_word(32'hF, 4, 3);
    send_word(32'h0, PAYLOAD_LEN, 3);
    check_eq("t3_count", got_n, PAYLOAD_LEN);
    check_eq("t3_seq", got_bits[9:0], KS_REF);

    // 4: flywheel through one bad header
    do_reset();
    send_word(32'hF, 4, 1);
    send_word(32'h0, PAYLOAD_LEN, 1);
    send_word(32'hB, 4, 1);
    check_eq("t4_locked", locked, 1);
    got_bits = '0; got_n = 0;
    send_word(32'h0, PAYLOAD_LEN, 1);
    check_eq("t4_seq", got_bits[9:0], KS_REF);
    check_eq("t4_errs", err_cnt, 1);

    // 5: two consecutive bad headers drop lock, then relock
    do_reset();
    send_word(32'hF, 4, 1);
    send_word(32'h0, PAYLOAD_LEN, 1);
    send_word(32'h0, 4, 1);
    send_word(32'h0, PAYLOAD_LEN, 1);
    send_word(32'h0, 4, 1);
    check_eq("t5_errs", err_cnt, 2);
    check_eq("t5_unlocked", locked, 0);
    send_word(32'hF, 4, 1);
    check_eq("t5_relock", locked, 1);

    // 6: overlapping hunt match, then reset in the middle of the payload
    do_reset();
    send_word(32'h3F, 6, 1);
    send_word(32'h0, 3, 1);
    check_eq("t6_bits_before_rst", got_n, 5);
    cycle(1'b0, 1'b1, 1'b1);
    check_eq("t6_rst_locked", locked, 0);
    got_n = 0;
    send_word(32'h0, 8, 1);
    check_eq("t6_silent", got_n, 0);
    send_word(32'hF, 4, 1);
    send_word(32'h0, PAYLOAD_LEN, 1);
    check_eq("t6_seq", got_bits[9:0], KS_REF);

    // random traffic with biased data, gaps and rare resets
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      cycle(($urandom_range(499, 0) != 0),
            ($urandom_range(9, 0) < 7),
            ($urandom_range(9, 0) < 6));
    end
    cycle(1'b1, 1'b0, 1'b0);
    check_eq("sb_drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
